mem_stage: RTL

//  Pipeline stage between EX and WB of the 64-bit 5-stage core. Registers the EX result bus, and for

---
 rtl/mem_stage_if.sv | 56 +++++
 rtl/mem_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Pipeline handshake and payload signals around the MEM stage:
//                EX->MEM bus, data-SRAM read return, MEM->WB bus and the
//                MEM->ID forward bus.
//                  master : environment (EX, SRAM, WB, ID side)
//                  slave  : the MEM stage itself
//                Ports (signal / driven by master or slave):
//                  ws_allowin        master  WB can accept this cycle
//                  es_to_ms_valid    master  EX bus valid
//                  es_to_ms_bus      master  EX payload
//                  data_sram_rdata   master  SRAM read data
//                  ms_allowin        slave   MEM can accept from EX
//                  ms_to_ws_valid    slave   MEM bus valid to WB
//                  ms_to_ws_bus      slave   payload to WB
//                  ms_to_ds_fwd_bus  slave   bypass to ID
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 138,
    parameter int MS_TO_WS_BUS_WD = 134,
    parameter int MS_FWD_BUS_WD   = 70
);
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [63:0]                data_sram_rdata;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_fwd_bus;

    modport master (
        output ws_allowin,
        output es_to_ms_valid,
        output es_to_ms_bus,
        output data_sram_rdata,
        input  ms_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        input  ms_to_ds_fwd_bus
    );

    modport slave (
        input  ws_allowin,
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  data_sram_rdata,
        output ms_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        output ms_to_ds_fwd_bus
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM pipeline stage of the 64-bit 5-stage core. Registers the
//                EX result bus and, for loads, selects/aligns/extends the
//                64-bit synchronous data-SRAM word. The SRAM word is only
//                present in the first MEM cycle, so it is captured in a
//                buffer when WB stalls the stage.
//                Ports:
//                  clk    in   clock, rising edge
//                  reset  in   asynchronous, active-high
//                  pipe   if   mem_stage_if.slave (handshake + buses)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  pipe
);
    localparam int       c_ES_WD = 138;
    localparam logic [2:0] c_LD_LB  = 3'b000;
    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LW  = 3'b010;
    localparam logic [2:0] c_LD_LD  = 3'b011;
    localparam logic [2:0] c_LD_LBU = 3'b100;
    localparam logic [2:0] c_LD_LHU = 3'b101;
    localparam logic [2:0] c_LD_LWU = 3'b110;

    logic              r_ms_valid;
    logic [c_ES_WD-1:0] r_es_bus;
    logic              r_ms_first;
    logic              r_rbuf_valid;
    logic [63:0]       r_rbuf;

    logic              w_ms_allowin;
    logic              w_accept;
    logic              w_res_from_mem;
    logic [2:0]        w_ld_type;
    logic              w_rf_we;
    logic [4:0]        w_rf_dest;
    logic [63:0]       w_alu_result;
    logic [63:0]       w_pc;
    logic [63:0]       w_rd;
    logic [63:0]       w_sh;
    logic [63:0]       w_load_data;
    logic [63:0]       w_result;

    assign w_res_from_mem = r_es_bus[137];
    assign w_ld_type      = r_es_bus[136:134];
    assign w_rf_we        = r_es_bus[133];
    assign w_rf_dest      = r_es_bus[132:128];
    assign w_alu_result   = r_es_bus[127:64];
    assign w_pc           = r_es_bus[63:0];

    // MEM never needs extra cycles, so it frees up whenever it is empty or WB takes its content.
    assign w_ms_allowin = !r_ms_valid | pipe.ws_allowin;
    assign w_accept     = w_ms_allowin & pipe.es_to_ms_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ms_valid   <= 1'b0;
            r_es_bus     <= '0;
            r_ms_first   <= 1'b0;
            r_rbuf_valid <= 1'b0;
            r_rbuf       <= '0;
        end else begin
            if (w_ms_allowin) begin
                r_ms_valid <= pipe.es_to_ms_valid;
            end
            // A bubble leaves the old payload in place; only valid is cleared.
            if (w_accept) begin
                r_es_bus <= pipe.es_to_ms_bus;
            end
            r_ms_first <= w_accept;
            // The SRAM word disappears after the first cycle: keep it if the load cannot leave now.
            // While this fires the stage is stalled, so w_accept cannot fire at the same edge.
            if (r_ms_first & r_ms_valid & w_res_from_mem & !pipe.ws_allowin) begin
                r_rbuf       <= pipe.data_sram_rdata;
                r_rbuf_valid <= 1'b1;
            end else if (w_accept | (r_ms_valid & pipe.ws_allowin)) begin
                r_rbuf_valid <= 1'b0;
            end
        end
    end

    // Live SRAM data in the first cycle, buffered copy on later stall cycles.
    assign w_rd = (r_ms_first | !r_rbuf_valid) ? pipe.data_sram_rdata : r_rbuf;
    assign w_sh = w_rd >> {w_alu_result[2:0], 3'b000};

    always_comb begin
        w_load_data = w_sh;
        case (w_ld_type)
            c_LD_LB:  w_load_data = {{56{w_sh[7]}},  w_sh[7:0]};
            c_LD_LH:  w_load_data = {{48{w_sh[15]}}, w_sh[15:0]};
            c_LD_LW:  w_load_data = {{32{w_sh[31]}}, w_sh[31:0]};
            c_LD_LD:  w_load_data = w_sh;
            c_LD_LBU: w_load_data = {56'd0, w_sh[7:0]};
            c_LD_LHU: w_load_data = {48'd0, w_sh[15:0]};
            c_LD_LWU: w_load_data = {32'd0, w_sh[31:0]};
            default:  w_load_data = w_sh;
        endcase
    end

    assign w_result = w_res_from_mem ? w_load_data : w_alu_result;

    assign pipe.ms_allowin       = w_ms_allowin;
    assign pipe.ms_to_ws_valid   = r_ms_valid;
    assign pipe.ms_to_ws_bus     = {w_rf_we, w_rf_dest, w_result, w_pc};
    // x0 destinations are still reported; ID discards them.
    assign pipe.ms_to_ds_fwd_bus = {r_ms_valid & w_rf_we, w_rf_dest, w_result};
endmodule
`default_nettype wire
